pll_cfg_switcher: RTL
=====================

Name: pll_cfg_switcher

Overview:
Controls the A/B configuration select shared by a bank of CC_PLL_ADV instances.
- Synchronises and debounces a user select request.
- Drives one common select line to all PLLs.
- Waits for every PLL to report lock, with a settle window and a lock timeout.
- Reports lock status, busy, fault and the failing channel mask.
- Runs on the board reference clock `clk`, upstream of the PLL bank.

Parameters:
CHANNELS, 4, number of PLLs monitored (1..16)
DEBOUNCE_BITS, 16, select request must be stable for 2^DEBOUNCE_BITS cycles
SETTLE_CYCLES, 64, cycles after a select change during which lock is ignored (>=1)
TIMEOUT_CYCLES, 1048576, maximum cycles in WAIT_LOCK before timeout (>=1)

Ports:
clk  in  1  reference clock; all logic on its rising edge
rst_n  in  1  asynchronous active-low reset
sel_req_i  in  1  asynchronous user select request (0=A, 1=B)
pll_locked_i  in  CHANNELS  asynchronous USR_PLL_LOCKED per PLL
fault_clr_i  in  1  synchronous pulse; leaves FAULT
pll_sel_o  out  1  registered select to every PLL USR_SEL_A_B
all_locked_o  out  1  high only in LOCKED
busy_o  out  1  high in SETTLE or WAIT_LOCK
fault_o  out  1  high in FAULT
fault_mask_o  out  CHANNELS  channels not locked at the last timeout; 1 = failed
switch_count_o  out  8  completed switches, saturating at 255

Behaviour:
- Reset values (async on rst_n low):
  - pll_sel_o=0, all_locked_o=0, busy_o=1, fault_o=0.
  - fault_mask_o=0, switch_count_o=0.
  - State=SETTLE; all counters 0.
- All outputs are registered.
- Synchronisation: sel_req_i and each pll_locked_i bit pass through a 2-flop synchroniser. Only synchronised values are used below (sel_s, lock_s).
- Debounce (active only in LOCKED):
  - Counter increments while sel_s != pll_sel_o; clears when they are equal or when not in LOCKED.
  - Reaching 2^DEBOUNCE_BITS-1 with the mismatch still present arms a switch.
  - A mismatch of 2^DEBOUNCE_BITS-1 cycles or fewer never switches.
- LOCKED:
  - If any lock_s bit is 0 → WAIT_LOCK (loss of lock; pll_sel_o unchanged; timeout counter cleared). Loss of lock wins over an armed switch on the same cycle.
  - Else, if a switch is armed → toggle pll_sel_o and go to SETTLE.
- SETTLE:
  - Counter runs 0..SETTLE_CYCLES-1, ignoring lock_s, then → WAIT_LOCK with the timeout counter cleared.
  - Exactly SETTLE_CYCLES cycles are spent in SETTLE.
- WAIT_LOCK:
  - All lock_s=1 → LOCKED. switch_count_o increments (saturating) only if this state was entered via a select toggle.
  - Timeout counter reaching TIMEOUT_CYCLES-1 with any lock_s=0 → capture fault_mask_o=~lock_s, then go to FAULT.
  - If all locks assert on the terminal timeout cycle, lock wins.
- FAULT:
  - pll_sel_o is held.
  - fault_clr_i=1 → SETTLE; fault_mask_o is retained until the next successful lock, where it clears to 0.
  - sel_s changes are ignored while in FAULT.
- sel_s changes in SETTLE or WAIT_LOCK are ignored. The debounce restarts on return to LOCKED.
- Latency, nominal PLLs: pll_sel_o toggles 2+2^DEBOUNCE_BITS to 3+2^DEBOUNCE_BITS cycles after a stable sel_req_i edge.
- Output timing:
  - all_locked_o rises on the cycle after the last lock_s bit rises, provided SETTLE has completed.
  - busy_o=1 exactly while in SETTLE or WAIT_LOCK.

Optional Feature:
Macro PLL_SW_REVERT_EN.

Defined (revert on failed switch):
- A timeout in WAIT_LOCK entered via a select toggle does the following instead of entering FAULT:
  - captures fault_mask_o;
  - toggles pll_sel_o back to its previous value;
  - sets an internal revert flag;
  - → SETTLE.
- While the revert flag is set, the debounce is blocked until sel_s equals pll_sel_o; the flag then clears.
- A timeout while already reverting → FAULT.
- switch_count_o does not increment on the reverted lock.

Undefined:
- Every timeout → FAULT.
- No revert logic is synthesised.

Test Plan:
Bench overrides: CHANNELS=4, DEBOUNCE_BITS=2, SETTLE_CYCLES=8, TIMEOUT_CYCLES=100.
- Reset with locks=4'hF → busy_o=1 for 8 settle cycles plus sync delay; all_locked_o=1 by cycle 12; pll_sel_o=0; switch_count_o=0.
- sel_req_i 0→1 held, then pll_locked_i drops to 0 for 20 cycles and returns to 4'hF → pll_sel_o=1 within 6–7 cycles of the edge; busy_o high; all_locked_o=1 after relock; switch_count_o=1.
- sel_req_i glitch to 1 for 3 cycles in LOCKED → pll_sel_o stays 0; switch_count_o stays 0.
- Switch requested, then pll_locked_i=4'b1011 held (macro undefined) → fault_o=1 after 8+100 cycles; fault_mask_o=4'b0100. Then fault_clr_i pulse with locks=4'hF → LOCKED; fault_mask_o=0.
- In LOCKED, pll_locked_i[2] drops for 5 cycles → all_locked_o falls ~3 cycles later; pll_sel_o unchanged; relock → all_locked_o=1; switch_count_o unchanged.
- PLL_SW_REVERT_EN defined: switch to 1 with channel 3 never locking on config B (lock restored after revert) → pll_sel_o returns to 0; fault_o=0; fault_mask_o=4'b1000; no further switch until sel_req_i returns to 0.

Source files
------------

// File: rtl/pll_cfg_switcher.sv
// pll_cfg_switcher: A/B configuration select controller for a bank of PLLs.
// Synchronises and debounces a user select request, drives one common select
// line, then supervises lock with a settle window and a lock timeout.
// Optional macro PLL_SW_REVERT_EN: a failed switch reverts to the previous
// configuration instead of entering FAULT.
module pll_cfg_switcher #(
    parameter int unsigned CHANNELS       = 4,
    parameter int unsigned DEBOUNCE_BITS  = 16,
    parameter int unsigned SETTLE_CYCLES  = 64,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sel_req_i,
    input  logic [CHANNELS-1:0] pll_locked_i,
    input  logic                fault_clr_i,
    output logic                pll_sel_o,
    output logic                all_locked_o,
    output logic                busy_o,
    output logic                fault_o,
    output logic [CHANNELS-1:0] fault_mask_o,
    output logic [7:0]          switch_count_o
);

    localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_LOCKED = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_FAULT  = 2'd3;

    logic                     sel_meta_q, sel_s_q;
    logic [CHANNELS-1:0]      lock_meta_q, lock_s_q;
    logic [1:0]               state_q, state_d;
    logic [DEBOUNCE_BITS-1:0] dbc_q, dbc_d;
    logic [SET_W-1:0]         set_q, set_d;
    logic [TMO_W-1:0]         tmo_q, tmo_d;
    logic                     sel_q, sel_d;
    logic                     toggled_q, toggled_d;
    logic [CHANNELS-1:0]      mask_q, mask_d;
    logic [7:0]               cnt_q, cnt_d;
    logic                     locked_q, busy_q, fault_q;
    logic                     all_lock, mismatch, dbc_block, armed;

`ifdef PLL_SW_REVERT_EN
    logic                     revert_q, revert_d;
    assign dbc_block = revert_q;
`else
    assign dbc_block = 1'b0;
`endif

    assign all_lock = &lock_s_q;
    assign mismatch = (sel_s_q != sel_q);
    assign armed    = mismatch && !dbc_block && (dbc_q == '1);

    // Two-flop synchronisers for the asynchronous request and lock inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_meta_q  <= 1'b0;
            sel_s_q     <= 1'b0;
            lock_meta_q <= '0;
            lock_s_q    <= '0;
        end else begin
            sel_meta_q  <= sel_req_i;
            sel_s_q     <= sel_meta_q;
            lock_meta_q <= pll_locked_i;
            lock_s_q    <= lock_meta_q;
        end
    end

    // Next-state logic: debounce, settle window, lock wait/timeout, fault
    always_comb begin
        state_d   = state_q;
        dbc_d     = '0;
        set_d     = set_q;
        tmo_d     = tmo_q;
        sel_d     = sel_q;
        toggled_d = toggled_q;
        mask_d    = mask_q;
        cnt_d     = cnt_q;
`ifdef PLL_SW_REVERT_EN
        revert_d  = revert_q;
`endif
        case (state_q)
            ST_LOCKED: begin
`ifdef PLL_SW_REVERT_EN
                if (revert_q && !mismatch) revert_d = 1'b0;
`endif
                if (!all_lock) begin
                    state_d   = ST_WAIT;
                    tmo_d     = '0;
                    toggled_d = 1'b0;
                end else if (armed) begin
                    sel_d     = !sel_q;
                    state_d   = ST_SETTLE;
                    set_d     = '0;
                    toggled_d = 1'b1;
                end else if (mismatch && !dbc_block) begin
                    dbc_d = dbc_q + DEBOUNCE_BITS'(1);
                end
            end
            ST_SETTLE: begin
                if (set_q == SET_LAST) begin
                    state_d = ST_WAIT;
                    tmo_d   = '0;
                end else begin
                    set_d = set_q + SET_W'(1);
                end
            end
            ST_WAIT: begin
                if (all_lock) begin
                    state_d   = ST_LOCKED;
                    toggled_d = 1'b0;
                    if (toggled_q && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
`ifdef PLL_SW_REVERT_EN
                    // The lock that ends a revert keeps the mask of the failed switch visible
                    if (!revert_q) mask_d = '0;
`else
                    mask_d = '0;
`endif
                end else if (tmo_q == TMO_LAST) begin
                    mask_d  = ~lock_s_q;
                    state_d = ST_FAULT;
`ifdef PLL_SW_REVERT_EN
                    if (toggled_q && !revert_q) begin
                        sel_d     = !sel_q;
                        revert_d  = 1'b1;
                        toggled_d = 1'b0;
                        state_d   = ST_SETTLE;
                        set_d     = '0;
                    end
`endif
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: begin
                if (fault_clr_i) begin
                    state_d   = ST_SETTLE;
                    set_d     = '0;
                    toggled_d = 1'b0;
                end
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_SETTLE;
            dbc_q     <= '0;
            set_q     <= '0;
            tmo_q     <= '0;
            sel_q     <= 1'b0;
            toggled_q <= 1'b0;
            mask_q    <= '0;
            cnt_q     <= '0;
            locked_q  <= 1'b0;
            busy_q    <= 1'b1;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            dbc_q     <= dbc_d;
            set_q     <= set_d;
            tmo_q     <= tmo_d;
            sel_q     <= sel_d;
            toggled_q <= toggled_d;
            mask_q    <= mask_d;
            cnt_q     <= cnt_d;
            locked_q  <= (state_d == ST_LOCKED);
            busy_q    <= (state_d == ST_SETTLE) || (state_d == ST_WAIT);
            fault_q   <= (state_d == ST_FAULT);
        end
    end

`ifdef PLL_SW_REVERT_EN
    // Revert flag: set by a failed switch, cleared once the request agrees again
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) revert_q <= 1'b0;
        else        revert_q <= revert_d;
    end
`endif

    assign pll_sel_o      = sel_q;
    assign all_locked_o   = locked_q;
    assign busy_o         = busy_q;
    assign fault_o        = fault_q;
    assign fault_mask_o   = mask_q;
    assign switch_count_o = cnt_q;

endmodule
